// File: rtl/wbdelaymem_pkg.sv
// Shared definitions for the delayed-response Wishbone memory: response
// types, delay-line record layout and the stall counter sizing helper.
package wbdelaymem_defs;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int RSP_W  = 1;

  typedef enum logic [RSP_W-1:0] {
    RSP_ACK = 1'b0,
    RSP_ERR = 1'b1
  } rsp_e;

  // One delay-line entry. 'keep' marks a stb-without-cyc error, which must
  // survive the cyc-low flush that squashes every other in-flight response.
  typedef struct packed {
    rsp_e              rsp;
    logic              keep;
    logic [DATA_W-1:0] data;
  } stage_t;

  // Accept counter must be able to hold the value 'period'; never zero wide.
  function automatic int acc_cnt_width(input int period);
    return (period < 1) ? 1 : $clog2(period + 1);
  endfunction

endpackage

// File: rtl/wbresp_pipe.sv
// Fixed-length response delay line: valid bits shift with asynchronous
// reset and a synchronous flush; payload registers are never reset.
module wbresp_pipe
  import wbdelaymem_defs::*;
#(
  parameter int STAGES = 2
) (
  input  logic   i_clk,
  input  logic   i_reset_n,
  input  logic   i_flush,
  input  logic   i_vld,
  input  stage_t i_stage,
  output logic   o_vld,
  output stage_t o_stage
);

  logic [STAGES-1:0] vld_p;
  stage_t            stg_p [STAGES];

  // Valid bits: load at the head, shift, drop everything not marked keep on flush
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= i_vld;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k] <= vld_p[k-1] && (!i_flush || stg_p[k-1].keep);
      end
    end
  end

  // Payload: plain shift, qualified only by the valid bits
  always_ff @(posedge i_clk) begin
    stg_p[0] <= i_stage;
    for (int k = 1; k < STAGES; k++) begin
      stg_p[k] <= stg_p[k-1];
    end
  end

  assign o_vld   = vld_p[STAGES-1];
  assign o_stage = stg_p[STAGES-1];

endmodule

// File: rtl/wbdelaymem.sv
// Pipelined Wishbone memory with programmable response latency, periodic
// stall injection and bus errors for addresses outside its window.
module wbdelaymem
  import wbdelaymem_defs::*;
#(
  parameter int AW           = 28,
  parameter int MAW          = 15,
  parameter int BASE         = 1,
  parameter int LATENCY      = 2,
  parameter int STALL_PERIOD = 0
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic [SEL_W-1:0]  i_wb_sel,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic [DATA_W-1:0] o_wb_data
);

  localparam int                CNT_W  = acc_cnt_width(STALL_PERIOD);
  localparam logic [AW-MAW-1:0] BASE_V = (AW-MAW)'(BASE);

  logic [DATA_W-1:0] mem [2**MAW];
  logic [MAW-1:0]    idx;
  logic              accept;
  logic              in_win;
  stage_t            stage_in;
  logic              out_vld;
  stage_t            out_stage;

  assign idx    = i_wb_addr[MAW-1:0];
  assign accept = i_wb_stb && !o_wb_stall;
  assign in_win = (i_wb_addr[AW-1:MAW] == BASE_V) && i_wb_cyc;

  // Byte-masked write at the accept edge; memory contents survive reset
  always_ff @(posedge i_clk) begin
    if (accept && in_win && i_wb_we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (i_wb_sel[b]) mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
      end
    end
  end

  // Build the delay-line entry; writes and errors carry zero data
  always_comb begin
    stage_in      = '0;
    stage_in.rsp  = in_win ? RSP_ACK : RSP_ERR;
    stage_in.keep = !i_wb_cyc;
    if (in_win && !i_wb_we) stage_in.data = mem[idx];
  end

  // ---- p0 .. p(LATENCY-1): response delay line ----
  wbresp_pipe #(
    .STAGES (LATENCY)
  ) u_pipe (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (!i_wb_cyc),
    .i_vld     (accept),
    .i_stage   (stage_in),
    .o_vld     (out_vld),
    .o_stage   (out_stage)
  );

  // The last stage is the output register; a response whose cycle coincides
  // with cyc low is suppressed, except the stb-without-cyc error.
  assign o_wb_ack  = out_vld && (out_stage.rsp == RSP_ACK) && i_wb_cyc;
  assign o_wb_err  = out_vld && (out_stage.rsp == RSP_ERR) && (i_wb_cyc || out_stage.keep);
  assign o_wb_data = o_wb_ack ? out_stage.data : '0;

  generate
    if (STALL_PERIOD == 0) begin : g_nostall
      assign o_wb_stall = 1'b0;
    end else begin : g_stall
      localparam logic [CNT_W-1:0] LAST = CNT_W'(STALL_PERIOD - 1);
      logic [CNT_W-1:0] acc_cnt;
      logic             stall_q;

      // Count accepts; the one that brings the count to STALL_PERIOD
      // wraps it to zero and raises stall for exactly the next cycle.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          acc_cnt <= '0;
          stall_q <= 1'b0;
        end else begin
          stall_q <= 1'b0;
          if (accept) begin
            if (acc_cnt == LAST) begin
              acc_cnt <= '0;
              stall_q <= 1'b1;
            end else begin
              acc_cnt <= acc_cnt + CNT_W'(1);
            end
          end
        end
      end

      assign o_wb_stall = stall_q;
    end
  endgenerate

endmodule
